firebird7_in_gate1_tessent_tdr_mux_ctrl: RTL and testbench
==========================================================

FIREBIRD7_IN_GATE1_TESSENT_TDR_MUX_CTRL -- requirements
Module: firebird7_in_gate1_tessent_tdr_mux_ctrl

Interface
REQ-001: Single clock ijtag_tck; synchronous, active-high reset ijtag_reset; all state SHALL update on the rising edge of ijtag_tck only.
REQ-002: ijtag_tck  input  1  scan/test clock.
REQ-003: ijtag_reset  input  1  synchronous active-high reset.
REQ-004: ijtag_sel  input  1  TDR select from the network; qualifies ce/se/ue.
REQ-005: ijtag_ce  input  1  capture enable.
REQ-006: ijtag_se  input  1  shift enable.
REQ-007: ijtag_ue  input  1  update enable.
REQ-008: ijtag_si  input  1  scan in.
REQ-009: data_obs_in  input  3  observed mux output, captured into the TDR.
REQ-010: ijtag_so  output  1  scan out.
REQ-011: ijtag_select  output  1  registered select driving the downstream 3-bit data mux.
REQ-012: ijtag_data_out  output  3  registered data driving the mux ijtag data input.

Function
REQ-013: 4-bit shift register sr[3:0]: sr[3] is select, sr[2:0] is data; 4-bit update register ur[3:0] drives ijtag_select=ur[3] and ijtag_data_out=ur[2:0] directly from flops.
REQ-014: Qualified strobes: cap=sel&ce, sft=sel&se, upd=sel&ue; with ijtag_sel=0 the TDR SHALL hold all state.
REQ-015: Priority when strobes coincide: reset > cap > sft > upd; only the highest-priority action occurs that cycle.
REQ-016: cap SHALL load sr <= {ur[3], data_obs_in} in one cycle.
REQ-017: sft SHALL load sr <= {ijtag_si, sr[3:1]}; first bit shifted in ends at sr[0] after 4 shifts.
REQ-018: ijtag_so SHALL equal sr[0] combinationally from the flop, with no added latency.
REQ-019: upd SHALL load ur <= sr; new ijtag_select/ijtag_data_out visible the cycle after upd is sampled.
REQ-020: Shifting more than 4 bits SHALL behave as a plain shift register; the last 4 bits shifted in are retained.
REQ-021: ur SHALL change only on upd or reset; cap and sft never disturb the outputs.

Reset
REQ-022: On ijtag_reset=1 at a clock edge: sr=4'b0000, ur=4'b0000, shift counter=0; thus ijtag_select=0 (functional path), ijtag_data_out=3'b000, ijtag_so=0.
REQ-023: Reset mid-capture/shift/update SHALL abort the operation; no partial update reaches ur.
REQ-024: Outputs SHALL remain at reset values until the first upd after reset deasserts.

Configuration
REQ-025: Macro FIREBIRD7_IN_GATE1_TDR_LEN_GUARD_EN compiles in a shift-length guard.
REQ-026: Defined: 3-bit counter cleared on cap, incremented on each sft, saturating at 7; upd SHALL load ur only if counter==4, else upd is ignored (ur unchanged); counter cleared on upd.
REQ-027: Not defined: no counter; every upd loads ur unconditionally; all other behaviour identical.

Verification
REQ-028: Reset: hold ijtag_reset=1 two cycles -> ijtag_select=0, ijtag_data_out=3'b000, ijtag_so=0.
REQ-029: Capture: ur=0, data_obs_in=3'b101, cap one cycle, then 4 shifts -> ijtag_so sequence 1,0,1,0.
REQ-030: Shift/update: cap, then shift si=1,1,0,1, then upd -> ijtag_select=1, ijtag_data_out=3'b011 on the next cycle.
REQ-031: Guard: cap, 3 shifts, upd -> outputs unchanged with macro defined; outputs updated without it.
REQ-032: Priority/select: ce=se=1 with sel=1 -> capture only; se=ue=1 with sel=0 -> sr and ur unchanged.
REQ-033: Reset mid-shift: after 2 of 4 shifts assert reset one cycle, then upd -> outputs remain 0 (counter=0 with macro defined; sr=0 without).

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctrl.sv
// IJTAG TDR controlling a downstream 3-bit data mux: a 4-bit shift register and a 4-bit update register.
// Optional macro FIREBIRD7_IN_GATE1_TDR_LEN_GUARD_EN: update is accepted only after exactly 4 shifts since capture.
module firebird7_in_gate1_tessent_tdr_mux_ctrl (
    input  logic       ijtag_tck,
    input  logic       ijtag_reset,
    input  logic       ijtag_sel,
    input  logic       ijtag_ce,
    input  logic       ijtag_se,
    input  logic       ijtag_ue,
    input  logic       ijtag_si,
    input  logic [2:0] data_obs_in,
    output logic       ijtag_so,
    output logic       ijtag_select,
    output logic [2:0] ijtag_data_out
);

    logic       cap;
    logic       sft;
    logic       upd;
    logic       upd_ok;
    logic [3:0] sr_q;
    logic [3:0] sr_d;
    logic [3:0] ur_q;
    logic [3:0] ur_d;

    assign cap = ijtag_sel & ijtag_ce;
    assign sft = ijtag_sel & ijtag_se;
    assign upd = ijtag_sel & ijtag_ue;

`ifdef FIREBIRD7_IN_GATE1_TDR_LEN_GUARD_EN
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Counter follows the same cap > sft > upd priority as the data path.
    always_comb begin
        cnt_d = cnt_q;
        if (cap) begin
            cnt_d = 3'd0;
        end else if (sft) begin
            cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
        end else if (upd) begin
            cnt_d = 3'd0;
        end
    end

    assign upd_ok = (cnt_q == 3'd4);

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign upd_ok = 1'b1;
`endif

    always_comb begin
        sr_d = sr_q;
        ur_d = ur_q;
        if (cap) begin
            sr_d = {ur_q[3], data_obs_in};
        end else if (sft) begin
            sr_d = {ijtag_si, sr_q[3:1]};
        end else if (upd && upd_ok) begin
            ur_d = sr_q;
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr_q <= 4'b0000;
            ur_q <= 4'b0000;
        end else begin
            sr_q <= sr_d;
            ur_q <= ur_d;
        end
    end

    assign ijtag_so       = sr_q[0];
    assign ijtag_select   = ur_q[3];
    assign ijtag_data_out = ur_q[2:0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_mux_ctrl.sv
// Scoreboard bench for the TDR mux controller: directed scenarios plus randomized transactions.
module tb_firebird7_in_gate1_tessent_tdr_mux_ctrl;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       ce;
    logic       se;
    logic       ue;
    logic       si;
    logic [2:0] obs;
    logic       so;
    logic       select_o;
    logic [2:0] data_o;

    logic [4:0] exp_q[$];
    int         n_cmp;
    int         n_fail;
    bit         done;

    // Reference state: shift register, update register, shifts since capture.
    int m_sr;
    int m_ur;
    int m_shifts;

    firebird7_in_gate1_tessent_tdr_mux_ctrl dut (
        .ijtag_tck      (clk),
        .ijtag_reset    (rst),
        .ijtag_sel      (sel),
        .ijtag_ce       (ce),
        .ijtag_se       (se),
        .ijtag_ue       (ue),
        .ijtag_si       (si),
        .data_obs_in    (obs),
        .ijtag_so       (so),
        .ijtag_select   (select_o),
        .ijtag_data_out (data_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] model_out();
        return {m_sr[0], m_ur[3], m_ur[2:0]};
    endfunction

    function automatic bit update_allowed();
`ifdef FIREBIRD7_IN_GATE1_TDR_LEN_GUARD_EN
        return (m_shifts == 4);
`else
        return 1'b1;
`endif
    endfunction

    // Apply one clock edge of the spec's rules to the reference model.
    function automatic void model_step(bit r, bit s, bit c, bit h, bit u, bit i, int o);
        if (r) begin
            m_sr = 0; m_ur = 0; m_shifts = 0;
        end else if (s && c) begin
            m_sr = (m_ur / 8) * 8 + o;
            m_shifts = 0;
        end else if (s && h) begin
            m_sr = (i ? 8 : 0) + m_sr / 2;
            m_shifts = (m_shifts >= 7) ? 7 : m_shifts + 1;
        end else if (s && u) begin
            if (update_allowed()) m_ur = m_sr;
            m_shifts = 0;
        end
    endfunction

    function automatic void check(string nm, logic [4:0] act, logic [4:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got so/sel/data=%b required %b at %0t", nm, act, req, $time);
        end
    endfunction

    // driver
    task automatic drive(bit r, bit s, bit c, bit h, bit u, bit i, logic [2:0] o);
        @(negedge clk);
        rst = r; sel = s; ce = c; se = h; ue = u; si = i; obs = o;
        @(posedge clk);
        model_step(r, s, c, h, u, i, int'(o));
        exp_q.push_back(model_out());
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic direct(string nm, logic [4:0] req);
        #1;
        check(nm, {so, select_o, data_o}, req);
    endtask

    // monitor: outputs are registered, so every edge presents a new response
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                logic [4:0] e;
                e = exp_q.pop_front();
                check("scoreboard", {so, select_o, data_o}, e);
            end
        end
    end

    initial begin
        logic [3:0] so_seq;
        logic [3:0] si_seq;
        n_cmp = 0; n_fail = 0; done = 0;
        m_sr = 0; m_ur = 0; m_shifts = 0;
        rst = 1; sel = 0; ce = 0; se = 0; ue = 0; si = 0; obs = 0;

        // Reset held two cycles
        drive(1, 0, 0, 0, 0, 0, 3'b111);
        drive(1, 1, 1, 1, 1, 1, 3'b111);
        direct("reset", 5'b0_0_000);

        // Capture 101 then shift out: so = 1,0,1,0
        so_seq = 4'b0101;
        drive(0, 1, 1, 0, 0, 0, 3'b101);
        direct("cap_so0", {so_seq[0], 4'b0000});
        for (int k = 1; k < 4; k++) begin
            drive(0, 1, 0, 1, 0, 0, 3'b000);
            direct("cap_so_seq", {so_seq[k], 4'b0000});
        end

        // Capture, shift 1,1,0,1, update -> select=1 data=011
        si_seq = 4'b1011;
        drive(0, 1, 1, 0, 0, 0, 3'b000);
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 1, 0, si_seq[k], 3'b000);
        drive(0, 1, 0, 0, 1, 0, 3'b000);
        #1;
        check("shift_update", {1'b0, select_o, data_o}, 5'b0_1_011);

        // Guard: capture 110, only 3 shifts of 1, update
        drive(1, 0, 0, 0, 0, 0, 3'b000);
        drive(0, 1, 1, 0, 0, 0, 3'b110);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 1, 0, 1, 3'b000);
        drive(0, 1, 0, 0, 1, 0, 3'b000);
        #1;
`ifdef FIREBIRD7_IN_GATE1_TDR_LEN_GUARD_EN
        check("guard_short", {1'b0, select_o, data_o}, 5'b0_0_000);
`else
        check("guard_short", {1'b0, select_o, data_o}, 5'b0_1_110);
`endif

        // Priority: ce and se together capture only; sel=0 holds everything
        drive(1, 0, 0, 0, 0, 0, 3'b000);
        drive(0, 1, 1, 1, 0, 1, 3'b011);
        direct("cap_over_shift", 5'b1_0_000);
        drive(0, 0, 0, 1, 1, 0, 3'b000);
        direct("sel_low_hold", 5'b1_0_000);

        // Reset mid-shift aborts; later update sees nothing
        drive(0, 1, 1, 0, 0, 0, 3'b111);
        drive(0, 1, 0, 1, 0, 1, 3'b000);
        drive(0, 1, 0, 1, 0, 1, 3'b000);
        drive(1, 0, 0, 0, 0, 0, 3'b000);
        drive(0, 1, 0, 0, 1, 0, 3'b000);
        direct("reset_mid_shift", 5'b0_0_000);

        // Randomized transactions with noise and occasional reset
        for (int t = 0; t < 150; t++) begin
            int n;
            drive($urandom_range(0, 39) == 0, 1, 1, $urandom_range(0, 1), 0, 0, 3'($urandom_range(0, 7)));
            n = $urandom_range(2, 6);
            for (int k = 0; k < n; k++) begin
                drive($urandom_range(0, 59) == 0, $urandom_range(0, 5) != 0, 0, 1,
                      $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)));
            end
            drive(0, $urandom_range(0, 7) != 0, 0, 0, 1, 0, 3'($urandom_range(0, 7)));
            for (int k = 0; k < 3; k++) begin
                drive($urandom_range(0, 49) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      3'($urandom_range(0, 7)));
            end
        end

        idle();
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses left, required 0", exp_q.size());
        end
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: run did not complete, required completion");
            $fatal(1, "timeout");
        end
    end

endmodule
